// File: rtl/gen3_scr_pkg.sv
// Shared constants and types for the Gen3 multi-lane scrambler: LFSR taps, lane seeds,
// sync-header and ordered-set symbol codes, and the block FSM state encoding.
package gen3_scr_pkg;

  localparam int          LFSR_W    = 23;
  // x^23 + x^21 + x^16 + x^8 + x^5 + x^2 + 1, with x^23 implicit in the shift-out bit
  localparam logic [22:0] LFSR_TAPS = 23'h210125;

  localparam logic [1:0]  SYNC_DATA = 2'b10;
  localparam logic [1:0]  SYNC_OS   = 2'b01;

  localparam logic [7:0]  OS_SKP    = 8'hAA;
  localparam logic [7:0]  OS_EIEOS  = 8'h00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA_BLK = 2'd1,
    OS_BLK   = 2'd2,
    SKP_BLK  = 2'd3
  } scr_state_e;

  // Only the low three bits select a seed; physical lane numbers repeat every 8 lanes.
  function automatic logic [LFSR_W-1:0] lane_seed(input logic [3:0] idx);
    logic [LFSR_W-1:0] seed;
    case (idx & 4'h7)
      4'd0:    seed = 23'h1DBFBC;
      4'd1:    seed = 23'h0607BB;
      4'd2:    seed = 23'h1EC760;
      4'd3:    seed = 23'h18C0DB;
      4'd4:    seed = 23'h010F12;
      4'd5:    seed = 23'h19CFC9;
      4'd6:    seed = 23'h0277CE;
      default: seed = 23'h1BB807;
    endcase
    return seed;
  endfunction

  // One serial step; the keystream bit for this step is s[LFSR_W-1] before the shift.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/gen3_lane_lfsr_adv.sv
// Combinational advance of one lane LFSR by BPL bytes; keystream byte b sits at
// ks_o[b*8 +: 8] with its first generated bit in the LSB.
module gen3_lane_lfsr_adv
  import gen3_scr_pkg::*;
#(
  parameter int BPL = 4
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [BPL*8-1:0]  ks_o
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s    = state_i;
    ks_o = '0;
    for (int i = 0; i < BPL*8; i++) begin
      ks_o[i] = s[LFSR_W-1];
      s       = lfsr_step(s);
    end
    state_o = s;
  end

endmodule

// File: rtl/gen3_multilane_scrambler.sv
// Multi-lane 128b/130b block scrambler with registered valid/ready output stage.
// Optional accepted-block counter is built only when GEN3_SCR_BLK_CNT_EN is defined.
//
// state    | meaning
// IDLE     | between blocks; next beat should carry block_start_i
// DATA_BLK | data block, bytes XORed with lane keystream when enabled
// OS_BLK   | ordered set, symbol 0 clear, symbols 1..15 scrambled
// SKP_BLK  | SKP ordered set or bad sync header: pass-through, LFSRs held
module gen3_multilane_scrambler
  import gen3_scr_pkg::*;
#(
  parameter int LANES = 4,
  parameter int BPL   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             lane_base_i,
  input  logic                   scramble_enable_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   block_start_i,
  input  logic [1:0]             sync_hdr_i,
  input  logic [LANES*BPL*8-1:0] data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [LANES*BPL*8-1:0] data_o,
  output logic                   err_o,
  output logic [15:0]            blk_cnt_o
);

  localparam int W     = LANES*BPL*8;
  localparam int BEATS = 16/BPL;
  localparam int CW    = $clog2(BEATS);

  scr_state_e        state_q, state_d, mode;
  logic [CW-1:0]     cnt_q, cnt_d, beat_idx;
  logic              eieos_q, eieos_d;
  logic              fresh_q, fresh_d;
  logic [LFSR_W-1:0] lfsr_q   [LANES];
  logic [LFSR_W-1:0] lfsr_d   [LANES];
  logic [LFSR_W-1:0] lfsr_cur [LANES];
  logic [LFSR_W-1:0] lfsr_adv [LANES];
  logic [BPL*8-1:0]  ks       [LANES];

  logic              valid_q, err_q, err_d;
  logic [W-1:0]      data_q, data_d;

  logic              accept, blk_start, misalign, bad_sync, blk_end;
  logic              lfsr_advance, lfsr_reload, scr_byte;

  assign ready_o   = !valid_q || ready_i;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign err_o     = err_q;

  // fresh_q stands in for "every lane holds its seed", so reset and EIEOS reload
  // need no lane_base_i-dependent register load.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lfsr_cur[l] = fresh_q ? lane_seed(lane_base_i + 4'(l)) : lfsr_q[l];

    gen3_lane_lfsr_adv #(.BPL(BPL)) u_adv (
      .state_i (lfsr_cur[l]),
      .state_o (lfsr_adv[l]),
      .ks_o    (ks[l])
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    eieos_d      = eieos_q;
    fresh_d      = fresh_q;
    accept       = valid_i && ready_o;
    blk_start    = accept && block_start_i;
    misalign     = blk_start && (cnt_q != '0);
    bad_sync     = 1'b0;
    mode         = state_q;
    beat_idx     = cnt_q;

    // A block_start beat always opens a new block, even mid-block.
    if (blk_start) begin
      beat_idx = '0;
      case (sync_hdr_i)
        SYNC_DATA: mode = DATA_BLK;
        SYNC_OS:   mode = (data_i[7:0] == OS_SKP) ? SKP_BLK : OS_BLK;
        default: begin
          mode     = SKP_BLK;
          bad_sync = 1'b1;
        end
      endcase
    end

    blk_end      = (mode != IDLE) && (beat_idx == CW'(BEATS-1));
    lfsr_advance = (mode == DATA_BLK) || (mode == OS_BLK);
    lfsr_reload  = (mode == OS_BLK) && blk_end && eieos_q;

    if (accept) begin
      if (blk_start) eieos_d = (data_i[7:0] == OS_EIEOS);
      if (mode != IDLE) begin
        if (blk_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = beat_idx + 1'b1;
          state_d = mode;
        end
      end
      if (lfsr_reload)       fresh_d = 1'b1;
      else if (lfsr_advance) fresh_d = 1'b0;
    end

    err_d = misalign || (blk_start && bad_sync);

    for (int l = 0; l < LANES; l++) begin
      lfsr_d[l] = (accept && lfsr_advance) ? lfsr_adv[l] : lfsr_q[l];
    end
  end

  always_comb begin
    data_d   = data_i;
    scr_byte = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < BPL; b++) begin
        case (mode)
          DATA_BLK: scr_byte = scramble_enable_i;
          OS_BLK:   scr_byte = !((beat_idx == '0) && (b == 0));
          default:  scr_byte = 1'b0;
        endcase
        if (scr_byte) begin
          data_d[(l*BPL+b)*8 +: 8] = data_i[(l*BPL+b)*8 +: 8] ^ ks[l][b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      eieos_q <= 1'b0;
      fresh_q <= 1'b1;
      for (int l = 0; l < LANES; l++) lfsr_q[l] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eieos_q <= eieos_d;
      fresh_q <= fresh_d;
      for (int l = 0; l < LANES; l++) lfsr_q[l] <= lfsr_d[l];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      if (ready_o) begin
        valid_q <= valid_i;
        if (valid_i) data_q <= data_d;
      end
    end
  end

`ifdef GEN3_SCR_BLK_CNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          blk_cnt_q <= '0;
    else if (blk_start) blk_cnt_q <= blk_cnt_q + 16'd1;
  end

  assign blk_cnt_o = blk_cnt_q;
`else
  assign blk_cnt_o = '0;
`endif

endmodule
